// File: rtl/interrupt_controller_pkg.sv
// Shared types and defaults for the interrupt controller: FSM encoding,
// parameter defaults and the fixed-priority (lowest index wins) encoder.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int          NUM_SRC_DEFAULT  = 4;
    localparam logic [13:0] VEC_BASE_DEFAULT = 14'h3F00;

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    function automatic logic [2:0] lowest_index(input logic [7:0] bits);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: two-flop synchronizer followed by a rising-edge
// detector whose history flop is registered.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= irq_in;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/interrupt_controller.sv
// Non-nesting interrupt controller: edge-triggered pending bits with overrun
// tracking, a mask register and a three-state request/acknowledge handshake.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int              NUM_SRC  = NUM_SRC_DEFAULT,
    parameter int              SIZE     = 14,
    parameter logic [SIZE-1:0] VEC_BASE = SIZE'(VEC_BASE_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_wrEn,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               ovr_clr,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               interrupt,
    output logic [SIZE-1:0]    vector,
    output logic [2:0]         active_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun
);

    state_t             state;
    logic [2:0]         active_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] overrun_q;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] ovr_set;
    logic [7:0]         req_bits;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_in (irq_src[i]),
            .rise   (rise[i])
        );
    end

    // A fresh edge landing on the ack cycle re-arms the bit instead of counting as lost.
    assign clr      = (state == REQ && int_ack) ? (NUM_SRC'(1) << active_q) : '0;
    assign ovr_set  = rise & pending_q & ~clr;
    assign req_bits = 8'(pending_q & mask_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | rise;
            overrun_q <= (ovr_clr ? '0 : overrun_q) | ovr_set;
            if (mask_wrEn) mask_q <= mask_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    active_q <= '0;
                    if (req_bits != 8'd0) begin
                        active_q <= lowest_index(req_bits);
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) state <= SERVICE;
                end
                SERVICE: begin
                    if (int_done) begin
                        state    <= IDLE;
                        active_q <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    active_q <= '0;
                end
            endcase
        end
    end

    assign interrupt = (state == REQ);
    assign active_id = active_q;
    assign vector    = (state == IDLE) ? '0 : VEC_BASE + SIZE'(active_q);
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (default parameters),
// with inputs driven 1 time unit after each rising clock edge.
module tb_interrupt_controller;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [3:0]  irq_src   = '0;
    logic        mask_wrEn = 1'b0;
    logic [3:0]  mask_data = '0;
    logic        ovr_clr   = 1'b0;
    logic        int_ack   = 1'b0;
    logic        int_done  = 1'b0;
    logic        interrupt;
    logic [13:0] vector;
    logic [2:0]  active_id;
    logic [3:0]  pending;
    logic [3:0]  overrun;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .mask_wrEn (mask_wrEn),
        .mask_data (mask_data),
        .ovr_clr   (ovr_clr),
        .int_ack   (int_ack),
        .int_done  (int_done),
        .interrupt (interrupt),
        .vector    (vector),
        .active_id (active_id),
        .pending   (pending),
        .overrun   (overrun)
    );

    // Drive one cycle of inputs, let the edge pass, then drop the strobes.
    task automatic applyStimulus(input logic [3:0] irq, input logic mwe, input logic [3:0] md,
                                 input logic oc, input logic ack, input logic done);
        irq_src   = irq;
        mask_wrEn = mwe;
        mask_data = md;
        ovr_clr   = oc;
        int_ack   = ack;
        int_done  = done;
        @(posedge clk);
        #1;
        mask_wrEn = 1'b0;
        ovr_clr   = 1'b0;
        int_ack   = 1'b0;
        int_done  = 1'b0;
    endtask

    task automatic idle(input logic [3:0] irq);
        applyStimulus(irq, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // Reset state
        idle(4'b0000);
        idle(4'b0000);
        checkOutput("rst_interrupt", 32'(interrupt), 32'd0);
        checkOutput("rst_vector",    32'(vector),    32'd0);
        checkOutput("rst_active_id", 32'(active_id), 32'd0);
        checkOutput("rst_pending",   32'(pending),   32'd0);
        checkOutput("rst_overrun",   32'(overrun),   32'd0);
        rst = 1'b0;
        idle(4'b0000);

        // Single source, latency and ack clears pending
        applyStimulus(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(4'b0001);
        checkOutput("t1_irq_edge1", 32'(interrupt), 32'd0);
        idle(4'b0001);
        checkOutput("t1_pend_edge2", 32'(pending), 32'd0);
        idle(4'b0001);
        checkOutput("t1_pend_edge3", 32'(pending), 32'h1);
        checkOutput("t1_irq_edge3", 32'(interrupt), 32'd0);
        idle(4'b0001);
        checkOutput("t1_irq_edge4", 32'(interrupt), 32'd1);
        checkOutput("t1_vector",    32'(vector),    32'h3F00);
        checkOutput("t1_active",    32'(active_id), 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_ack_pend", 32'(pending),   32'd0);
        checkOutput("t1_ack_irq",  32'(interrupt), 32'd0);
        checkOutput("t1_svc_vec",  32'(vector),    32'h3F00);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_done_vec", 32'(vector), 32'd0);
        idle(4'b0000);
        idle(4'b0000);
        idle(4'b0000);

        // Simultaneous edges: lowest index first, then the next
        applyStimulus(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        idle(4'b0110);
        idle(4'b0110);
        idle(4'b0110);
        checkOutput("t2_pend", 32'(pending), 32'h6);
        idle(4'b0110);
        checkOutput("t2_irq",    32'(interrupt), 32'd1);
        checkOutput("t2_active", 32'(active_id), 32'd1);
        checkOutput("t2_vector", 32'(vector),    32'h3F01);
        applyStimulus(4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_done_ignored", 32'(interrupt), 32'd1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_ack_pend",   32'(pending),   32'h4);
        checkOutput("t2_ack_active", 32'(active_id), 32'd1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_idle_active", 32'(active_id), 32'd0);
        checkOutput("t2_idle_irq",    32'(interrupt), 32'd0);
        idle(4'b0000);
        checkOutput("t2_next_irq",    32'(interrupt), 32'd1);
        checkOutput("t2_next_active", 32'(active_id), 32'd2);
        checkOutput("t2_next_vector", 32'(vector),    32'h3F02);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_next_pend", 32'(pending), 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(4'b0000);
        idle(4'b0000);
        idle(4'b0000);

        // Masked source stays pending, unmasking raises the request
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(4'b1000);
        idle(4'b1000);
        idle(4'b1000);
        checkOutput("t3_pend", 32'(pending), 32'h8);
        idle(4'b1000);
        checkOutput("t3_masked_irq", 32'(interrupt), 32'd0);
        applyStimulus(4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_unmask_irq0", 32'(interrupt), 32'd0);
        idle(4'b1000);
        checkOutput("t3_unmask_irq1", 32'(interrupt), 32'd1);
        checkOutput("t3_active",      32'(active_id), 32'd3);
        checkOutput("t3_vector",      32'(vector),    32'h3F03);
        applyStimulus(4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_remask_keeps", 32'(interrupt), 32'd1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_ack_pend", 32'(pending), 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(4'b0000);
        idle(4'b0000);
        idle(4'b0000);
        checkOutput("t3_quiet_irq", 32'(interrupt), 32'd0);

        // Overrun on a second edge while pending, then cleared
        idle(4'b0001);
        idle(4'b0000);
        idle(4'b0000);
        idle(4'b0000);
        checkOutput("t4_pend",    32'(pending), 32'h1);
        checkOutput("t4_no_ovr",  32'(overrun), 32'd0);
        idle(4'b0001);
        idle(4'b0000);
        idle(4'b0000);
        idle(4'b0000);
        checkOutput("t4_ovr_set",  32'(overrun), 32'h1);
        checkOutput("t4_pend_hold", 32'(pending), 32'h1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_ovr_clr", 32'(overrun), 32'd0);

        // New edge coincides with the ack of the same source
        applyStimulus(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(4'b0000);
        checkOutput("t5_req_irq",    32'(interrupt), 32'd1);
        checkOutput("t5_req_active", 32'(active_id), 32'd0);
        idle(4'b0001);
        idle(4'b0000);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_pend_kept", 32'(pending),   32'h1);
        checkOutput("t5_no_ovr",    32'(overrun),   32'd0);
        checkOutput("t5_svc_irq",   32'(interrupt), 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(4'b0000);
        checkOutput("t5_reissue_irq", 32'(interrupt), 32'd1);
        checkOutput("t5_reissue_vec", 32'(vector),    32'h3F00);

        // Reset during SERVICE aborts immediately
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_svc_vec", 32'(vector), 32'h3F00);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_irq",     32'(interrupt), 32'd0);
        checkOutput("t6_rst_vector",  32'(vector),    32'd0);
        checkOutput("t6_rst_active",  32'(active_id), 32'd0);
        checkOutput("t6_rst_pending", 32'(pending),   32'd0);
        checkOutput("t6_rst_overrun", 32'(overrun),   32'd0);
        idle(4'b0000);
        rst = 1'b0;
        idle(4'b0000);
        idle(4'b0000);
        idle(4'b0000);
        idle(4'b0000);
        checkOutput("t6_post_irq",  32'(interrupt), 32'd0);
        checkOutput("t6_post_pend", 32'(pending),   32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt sources; valid range 2..8.
REQ-002 Parameter SIZE, default 14: RAM address width; matches the CPU address width.
REQ-003 Parameter VEC_BASE, default 14'h3F00: address of source 0's vector; source i uses VEC_BASE+i.
REQ-004 clk  input  1  single clock; every register samples on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 irq_src  input  NUM_SRC  asynchronous level lines from peripherals; a rising edge is one event.
REQ-007 mask_wrEn  input  1  mask register write strobe, one cycle.
REQ-008 mask_data  input  NUM_SRC  new mask value; 1 enables the source.
REQ-009 ovr_clr  input  1  clears all overrun flags.
REQ-010 int_ack  input  1  CPU accepts the request; one-cycle pulse.
REQ-011 int_done  input  1  CPU finished the ISR; one-cycle pulse.
REQ-012 interrupt  output  1  request to the CPU; drives the CPU interrupt input.
REQ-013 vector  output  SIZE  address the CPU reads the ISR entry from.
REQ-014 active_id  output  3  index of the source being requested or served.
REQ-015 pending  output  NUM_SRC  pending register, unmasked view.
REQ-016 overrun  output  NUM_SRC  sticky lost-event flags.

Function
REQ-017 Each irq_src bit SHALL pass through a two-flop synchronizer and then a registered rising-edge detector.
REQ-018 A detected edge SHALL set pending[i] regardless of the mask.
REQ-019 An edge on a source whose pending bit is already 1 SHALL set overrun[i].
REQ-020 overrun[i] SHALL clear only on ovr_clr or rst; if ovr_clr and a new overrun occur in the same cycle, set wins.
REQ-021 mask SHALL load mask_data on the cycle mask_wrEn is high.
REQ-022 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-023 IDLE: if (pending & mask) != 0, latch the lowest set index into active_id and go to REQ; otherwise stay in IDLE.
REQ-024 REQ: interrupt = 1; on int_ack, clear pending[active_id] and go to SERVICE.
REQ-025 SERVICE: interrupt = 0; on int_done, return to IDLE.
REQ-026 There is no nesting; pending requests wait in SERVICE.
REQ-027 interrupt SHALL be a pure decode of state == REQ.
REQ-028 vector SHALL equal VEC_BASE + active_id (modulo 2^SIZE) in REQ and SERVICE, and 0 in IDLE.
REQ-029 active_id SHALL be 0 in IDLE.
REQ-030 Latency: with irq_src high at clock edge N and the source unmasked, pending is set at edge N+2 and interrupt rises at edge N+3.
REQ-031 When the pending clear of REQ-024 and a new edge on the same source occur in the same cycle, pending[i] SHALL stay 1 and overrun SHALL not be set.
REQ-032 int_ack outside REQ and int_done outside SERVICE SHALL be ignored.
REQ-033 Masking the active source while in REQ or SERVICE SHALL not cancel the request in progress.
REQ-034 Priority SHALL be re-evaluated only in IDLE; a higher-priority edge arriving during REQ does not preempt.

Reset
REQ-035 While rst is high: state = IDLE; synchronizers, edge registers, pending, overrun and mask = 0 (all sources masked); interrupt = 0; vector = 0; active_id = 0.
REQ-036 rst asserted mid-REQ or mid-SERVICE SHALL abort immediately, with no pending bit preserved.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (IDLE=0, REQ=1, SERVICE=2), the NUM_SRC default and the VEC_BASE default.
REQ-038 One sub-module, irq_sync_edge (synchronizer plus edge detector, one bit), SHALL be instantiated NUM_SRC times.

Verification
REQ-039 mask=4'b0001; pulse irq_src[0] -> interrupt high at the 4th edge; vector=14'h3F00; int_ack -> pending=0 and interrupt low.
REQ-040 mask=4'b1111; edges on sources 2 and 1 in the same cycle -> active_id=1, vector=14'h3F01; after int_ack and int_done -> active_id=2, vector=14'h3F02.
REQ-041 mask=0; edge on irq_src[3] -> pending=4'b1000 and interrupt stays 0; write mask=4'b1000 -> interrupt rises 1 cycle later.
REQ-042 Source 0 pending with no ack; a second edge on source 0 -> overrun[0]=1; ovr_clr -> overrun=0.
REQ-043 A new edge on the active source lands in the int_ack cycle -> pending[0] stays 1 and overrun[0]=0.
REQ-044 rst asserted in SERVICE -> all outputs 0 in the same cycle, and no interrupt after rst is released.
